// File: rtl/cd_tx_ram.sv
// cd_tx_ram: double-buffered TX frame RAM; CSR writes 32-bit words, engine reads bytes from the queued page.
// Optional CD_TX_RAM_LEN_SNOOP_EN adds per-page frame-length snooping on tx_frame_len.
module cd_tx_ram #(
    parameter int PAGE_AW = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_ram_wr_en,
    input  logic [PAGE_AW-1:0] tx_ram_wr_addr,
    input  logic [31:0]        tx_ram_wr_word,
    input  logic               tx_ram_switch,
    input  logic               tx_abort,
    output logic               tx_pending,
    output logic               switch_lost,
    output logic               tx_req,
    input  logic               tx_start,
    input  logic               tx_done,
    input  logic               tx_retry,
    input  logic [PAGE_AW+1:0] tx_rd_addr,
    output logic [7:0]         tx_rd_data,
    output logic               tx_kill
`ifdef CD_TX_RAM_LEN_SNOOP_EN
    ,
    output logic [7:0]         tx_frame_len
`endif
);
    localparam int DEPTH = 1 << PAGE_AW;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] QUEUED = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    logic [31:0] mem [2*DEPTH];
    logic        wr_sel;
    logic [1:0]  st;
    logic [1:0]  st_h;
    logic        accept;
    logic [31:0] rd_word;

    // Engine handshake and abort resolve first; a switch only sees the result.
    always_comb begin
        st_h   = tx_abort                    ? FREE   :
                 (tx_start && st == QUEUED)  ? ACTIVE :
                 (tx_retry && st == ACTIVE)  ? QUEUED :
                 (tx_done  && st == ACTIVE)  ? FREE   : st;
        accept = tx_ram_switch && st_h == FREE;
    end

    assign tx_req     = st == QUEUED;
    assign tx_pending = st != FREE;
    assign rd_word    = mem[{~wr_sel, tx_rd_addr[PAGE_AW+1:2]}];

    always_ff @(posedge clk)
        if (tx_ram_wr_en)
            mem[{wr_sel, tx_ram_wr_addr}] <= tx_ram_wr_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_sel      <= 1'b0;
            st          <= FREE;
            switch_lost <= 1'b0;
            tx_kill     <= 1'b0;
            tx_rd_data  <= 8'd0;
        end else begin
            wr_sel      <= wr_sel ^ accept;
            st          <= accept ? QUEUED : st_h;
            switch_lost <= tx_ram_switch && !accept;
            tx_kill     <= tx_abort && st == ACTIVE;
            tx_rd_data  <= rd_word[{tx_rd_addr[1:0], 3'b000} +: 8];
        end
    end

`ifdef CD_TX_RAM_LEN_SNOOP_EN
    logic [7:0] len [2];

    always_ff @(posedge clk) begin
        if (reset) begin
            len[0] <= 8'd3;
            len[1] <= 8'd3;
        end else if (tx_ram_wr_en && tx_ram_wr_addr == '0) begin
            len[wr_sel] <= tx_ram_wr_word[23:16] + 8'd3;
        end
    end

    assign tx_frame_len = len[~wr_sel];
`endif
endmodule

// File: tb/tb_cd_tx_ram.sv
// tb_cd_tx_ram: directed self-checking bench for cd_tx_ram.
module tb_cd_tx_ram;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          tx_ram_wr_en;
    logic [AW-1:0] tx_ram_wr_addr;
    logic [31:0]   tx_ram_wr_word;
    logic          tx_ram_switch;
    logic          tx_abort;
    logic          tx_pending;
    logic          switch_lost;
    logic          tx_req;
    logic          tx_start;
    logic          tx_done;
    logic          tx_retry;
    logic [AW+1:0] tx_rd_addr;
    logic [7:0]    tx_rd_data;
    logic          tx_kill;
`ifdef CD_TX_RAM_LEN_SNOOP_EN
    logic [7:0]    tx_frame_len;
`endif

    int n_chk = 0;
    int n_pass = 0;

    cd_tx_ram #(.PAGE_AW(AW)) dut (
        .clk(clk), .reset(reset),
        .tx_ram_wr_en(tx_ram_wr_en), .tx_ram_wr_addr(tx_ram_wr_addr), .tx_ram_wr_word(tx_ram_wr_word),
        .tx_ram_switch(tx_ram_switch), .tx_abort(tx_abort),
        .tx_pending(tx_pending), .switch_lost(switch_lost), .tx_req(tx_req),
        .tx_start(tx_start), .tx_done(tx_done), .tx_retry(tx_retry),
        .tx_rd_addr(tx_rd_addr), .tx_rd_data(tx_rd_data), .tx_kill(tx_kill)
`ifdef CD_TX_RAM_LEN_SNOOP_EN
        , .tx_frame_len(tx_frame_len)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clr();
        {tx_ram_wr_en, tx_ram_switch, tx_abort, tx_start, tx_done, tx_retry} = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] w);
        tx_ram_wr_en = 1'b1; tx_ram_wr_addr = a; tx_ram_wr_word = w;
        step(); clr();
    endtask

    logic [7:0] exp_bytes [8] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

    initial begin
        clr(); reset = 1'b1; tx_ram_wr_addr = '0; tx_ram_wr_word = '0; tx_rd_addr = '0;
        step(); step(); reset = 1'b0;
        chk("rst_pending", tx_pending, 0);
        chk("rst_req", tx_req, 0);
        chk("rst_lost", switch_lost, 0);
        chk("rst_kill", tx_kill, 0);
        chk("rst_rd", tx_rd_data, 0);
        chk("rst_wr_sel", dut.wr_sel, 0);

        wr(0, 32'h00030201);
        wr(1, 32'hDDCCBBAA);
        tx_ram_switch = 1'b1; step(); clr();
        chk("sw_req", tx_req, 1);
        chk("sw_pending", tx_pending, 1);
        chk("sw_wr_sel", dut.wr_sel, 1);
        chk("sw_lost", switch_lost, 0);
        for (int i = 0; i < 8; i++) begin
            tx_rd_addr = 8'(i); step();
            chk($sformatf("rd_byte%0d", i), tx_rd_data, exp_bytes[i]);
        end

        tx_ram_switch = 1'b1; step(); clr();
        chk("lost_pulse", switch_lost, 1);
        chk("lost_wr_sel", dut.wr_sel, 1);
        tx_rd_addr = 8'd4; step();
        chk("lost_once", switch_lost, 0);
        chk("lost_contents", tx_rd_data, 8'hAA);

        tx_start = 1'b1; step(); clr();
        chk("hs_active_req", tx_req, 0);
        chk("hs_active_pend", tx_pending, 1);
        tx_retry = 1'b1; step(); clr();
        chk("hs_retry_req", tx_req, 1);
        tx_start = 1'b1; step(); clr();
        chk("hs_restart_req", tx_req, 0);
        tx_done = 1'b1; step(); clr();
        chk("hs_done_pend", tx_pending, 0);
        chk("hs_done_req", tx_req, 0);

        tx_ram_switch = 1'b1; step(); clr();
        tx_start = 1'b1; step(); clr();
        tx_abort = 1'b1; tx_done = 1'b1; step(); clr();
        chk("abort_pend", tx_pending, 0);
        chk("abort_kill", tx_kill, 1);
        step();
        chk("abort_kill_end", tx_kill, 0);
        tx_ram_switch = 1'b1; step(); clr();
        chk("q_abort_req", tx_req, 1);
        tx_abort = 1'b1; step(); clr();
        chk("q_abort_kill", tx_kill, 0);
        chk("q_abort_pend", tx_pending, 0);
        chk("q_abort_wr_sel", dut.wr_sel, 1);

        tx_ram_switch = 1'b1; step(); clr();
        tx_start = 1'b1; step(); clr();
        tx_done = 1'b1; tx_ram_switch = 1'b1;
        tx_ram_wr_en = 1'b1; tx_ram_wr_addr = 6'd2; tx_ram_wr_word = 32'h11223344;
        step(); clr();
        chk("ds_lost", switch_lost, 0);
        chk("ds_req", tx_req, 1);
        chk("ds_wr_sel", dut.wr_sel, 1);
        tx_rd_addr = 8'd8; step();
        chk("ds_byte8", tx_rd_data, 8'h44);
        tx_rd_addr = 8'd11; step();
        chk("ds_byte11", tx_rd_data, 8'h11);
        tx_rd_addr = 8'd0; step();
        chk("ds_byte0", tx_rd_data, 8'h01);

        tx_start = 1'b1; step(); clr();
        tx_retry = 1'b1; tx_ram_switch = 1'b1; step(); clr();
        chk("rs_lost", switch_lost, 1);
        chk("rs_req", tx_req, 1);
        chk("rs_wr_sel", dut.wr_sel, 1);

        tx_start = 1'b1; step(); clr();
        reset = 1'b1; step(); reset = 1'b0;
        chk("mid_rst_pend", tx_pending, 0);
        chk("mid_rst_kill", tx_kill, 0);
        chk("mid_rst_wr_sel", dut.wr_sel, 0);

`ifdef CD_TX_RAM_LEN_SNOOP_EN
        chk("len_rst", tx_frame_len, 8'd3);
        wr(0, 32'h00050201);
        tx_ram_switch = 1'b1; step(); clr();
        chk("len_snoop", tx_frame_len, 8'd8);
        tx_start = 1'b1; step(); clr();
        reset = 1'b1; step(); reset = 1'b0;
        chk("len_mid_rst", tx_frame_len, 8'd3);
        chk("len_mid_rst_pend", tx_pending, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
